// File: rtl/hamming74_pkg.sv
// Shared Hamming (7,4) definitions: codeword bit positions, syndrome type and
// helpers used by both the encoder and the decoder.
package hamming74_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;

    // Codeword bit i holds Hamming position i+1.
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int D0_IDX = 2;
    localparam int P3_IDX = 3;
    localparam int D1_IDX = 4;
    localparam int D2_IDX = 5;
    localparam int D3_IDX = 6;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [2:0]        syndrome_t;

    // Bit p set when Hamming position p carries a data bit: {3,5,6,7}.
    localparam logic [7:0] DATA_POS_MASK = 8'b1110_1000;

    function automatic syndrome_t calc_syndrome(input code_t c);
        syndrome_t s;
        s[0] = c[P1_IDX] ^ c[D0_IDX] ^ c[D1_IDX] ^ c[D3_IDX];
        s[1] = c[P2_IDX] ^ c[D0_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
        s[2] = c[P3_IDX] ^ c[D1_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
        return s;
    endfunction

    function automatic logic is_data_pos(input syndrome_t s);
        return DATA_POS_MASK[s];
    endfunction

    function automatic data_t extract_data(input code_t c);
        return {c[D3_IDX], c[D2_IDX], c[D1_IDX], c[D0_IDX]};
    endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational syndrome computation and single-bit correction of one codeword.
module hamming74_syndrome
    import hamming74_pkg::*;
(
    input  code_t     code_i,
    output syndrome_t syndrome_o,
    output data_t     data_o
);

    code_t flip;
    code_t fixed;

    assign syndrome_o = calc_syndrome(code_i);

    // A nonzero syndrome names the faulty position directly (1-based).
    always_comb begin
        flip = '0;
        if (syndrome_o != '0) begin
            flip = code_t'(1) << (syndrome_o - 3'd1);
        end
        fixed = code_i ^ flip;
    end

    assign data_o = extract_data(fixed);

endmodule

// File: rtl/hamming74_decoder.sv
// Two-stage Hamming (7,4) decoder with valid/ready handshake, whole-pipe stall
// and a saturating count of corrected output words.
module hamming74_decoder
    import hamming74_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_err,
    output logic             out_data_err,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] err_count
);

    logic             adv;
    logic             out_xfer;

    logic             s1_vld_q, s1_vld_d;
    code_t            s1_code_q, s1_code_d;
    syndrome_t        s1_syn_q, s1_syn_d;

    logic             s2_vld_q, s2_vld_d;
    data_t            s2_data_q, s2_data_d;
    syndrome_t        s2_syn_q, s2_syn_d;
    logic             s2_err_q, s2_err_d;
    logic             s2_derr_q, s2_derr_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    syndrome_t        fix_syn;
    data_t            fix_data;

    hamming74_syndrome u_fix (
        .code_i     (s1_code_q),
        .syndrome_o (fix_syn),
        .data_o     (fix_data)
    );

    assign adv      = !s2_vld_q || out_ready;
    assign in_ready = adv;
    assign out_xfer = s2_vld_q && out_ready;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_code_d = s1_code_q;
        s1_syn_d  = s1_syn_q;
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;
        s2_syn_d  = s2_syn_q;
        s2_err_d  = s2_err_q;
        s2_derr_d = s2_derr_q;
        if (adv) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code;
                s1_syn_d  = calc_syndrome(in_code);
            end
            s2_vld_d = s1_vld_q;
            // Flags come off the registered S1 syndrome, keeping them off the correction path.
            if (s1_vld_q) begin
                s2_data_d = fix_data;
                s2_syn_d  = fix_syn;
                s2_err_d  = (s1_syn_q != '0);
                s2_derr_d = is_data_pos(s1_syn_q);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (out_xfer && s2_err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_code_q <= '0;
            s1_syn_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_syn_q  <= '0;
            s2_err_q  <= 1'b0;
            s2_derr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_code_q <= s1_code_d;
            s1_syn_q  <= s1_syn_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
            s2_syn_q  <= s2_syn_d;
            s2_err_q  <= s2_err_d;
            s2_derr_q <= s2_derr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid    = s2_vld_q;
    assign out_data     = s2_data_q;
    assign out_syndrome = s2_syn_q;
    assign out_err      = s2_err_q;
    assign out_data_err = s2_derr_q;
    assign err_count    = cnt_q;

endmodule

// File: tb/tb_hamming74_decoder.sv
// Directed plus randomized bench for hamming74_decoder, scored against a
// position-arithmetic reference model with a queue-based scoreboard.
module tb_hamming74_decoder;

    localparam int CNT_W  = 2;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_code = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       out_data;
    logic [2:0]       out_syndrome;
    logic             out_err;
    logic             out_data_err;
    logic             cnt_clear = 1'b0;
    logic [CNT_W-1:0] err_count;

    hamming74_decoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_err      (out_err),
        .out_data_err (out_data_err),
        .cnt_clear    (cnt_clear),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [2:0] s;
        logic       e;
        logic       de;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   mcnt  = 0;
    int   n_sent = 0;
    exp_t q[$];
    bit   held = 0;
    exp_t hv;

    // Syndrome is the XOR of the Hamming positions of all set bits.
    function automatic exp_t ref_decode(input logic [6:0] code);
        logic [6:0] c;
        int syn;
        exp_t r;
        c = code;
        syn = 0;
        for (int i = 0; i < 7; i++) if (c[i]) syn ^= (i + 1);
        if (syn != 0) c[syn-1] = ~c[syn-1];
        r.d  = {c[6], c[5], c[4], c[2]};
        r.s  = syn[2:0];
        r.e  = (syn != 0);
        r.de = (syn == 3) || (syn == 5) || (syn == 6) || (syn == 7);
        return r;
    endfunction

    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        int dpos [4] = '{3, 5, 6, 7};
        logic [6:0] c;
        int x;
        c = '0;
        x = 0;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) begin
                c[dpos[i]-1] = 1'b1;
                x ^= dpos[i];
            end
        end
        if (x[0]) c[0] = 1'b1;
        if (x[1]) c[1] = 1'b1;
        if (x[2]) c[3] = 1'b1;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [6:0] c, input logic r, input logic clr);
        exp_t e;
        in_valid  = v;
        in_code   = c;
        out_ready = r;
        cnt_clear = clr;
        @(negedge clk);
        chk("err_count", 32'(err_count), 32'(mcnt));
        chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(hv.d));
            chk("hold_syn", 32'(out_syndrome), 32'(hv.s));
            chk("hold_err", 32'({out_err, out_data_err}), 32'({hv.e, hv.de}));
        end
        held = 0;
        if (clr) mcnt = 0;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_syndrome", 32'(out_syndrome), 32'(e.s));
                chk("out_err", 32'(out_err), 32'(e.e));
                chk("out_data_err", 32'(out_data_err), 32'(e.de));
                if (!clr && e.e && mcnt < CNT_MAX) mcnt++;
            end
        end
        if (out_valid && !out_ready) begin
            held = 1;
            hv.d = out_data; hv.s = out_syndrome; hv.e = out_err; hv.de = out_data_err;
        end
        if (v && in_ready) begin
            q.push_back(ref_decode(c));
            n_sent++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mcnt = 0;
        held = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] cw;
        int guard;

        // Reset state.
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_syn", 32'(out_syndrome), 32'd0);
        chk("rst_flags", 32'({out_err, out_data_err}), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("encode_ref", 32'(ref_encode(4'b1011)), 32'h55);

        // Clean word with 2-cycle latency.
        step(1'b1, 7'h55, 1'b1, 1'b0);
        chk("lat_s1", 32'(out_valid), 32'd0);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        chk("lat_s2", 32'(out_valid), 32'd1);
        chk("clean_data", 32'(out_data), 32'hB);
        chk("clean_syn", 32'(out_syndrome), 32'd0);
        chk("clean_err", 32'(out_err), 32'd0);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        chk("clean_cnt", 32'(err_count), 32'd0);

        // Data-bit error at position 5.
        step(1'b1, 7'h45, 1'b1, 1'b0);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        chk("derr_data", 32'(out_data), 32'hB);
        chk("derr_syn", 32'(out_syndrome), 32'd5);
        chk("derr_flags", 32'({out_err, out_data_err}), 32'b11);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        chk("derr_cnt", 32'(err_count), 32'd1);

        // Parity-bit error at position 1.
        step(1'b1, 7'h54, 1'b1, 1'b0);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        chk("perr_data", 32'(out_data), 32'hB);
        chk("perr_syn", 32'(out_syndrome), 32'd1);
        chk("perr_flags", 32'({out_err, out_data_err}), 32'b10);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        chk("perr_cnt", 32'(err_count), 32'd2);

        // Random stream with random backpressure, including double-bit errors.
        n_sent = 0;
        guard = 0;
        while (n_sent < 24 && guard < 400) begin
            cw = ref_encode(4'($urandom_range(0, 15)));
            case ($urandom_range(0, 3))
                0: ;
                1, 2: cw[$urandom_range(0, 6)] ^= 1'b1;
                default: begin
                    cw[0] ^= 1'b1;
                    cw[$urandom_range(1, 6)] ^= 1'b1;
                end
            endcase
            step(1'($urandom_range(0, 1)), cw, 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        chk("stream_sent", 32'(n_sent >= 24), 32'd1);
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            step(1'b0, 7'h00, 1'b1, 1'b0);
            guard++;
        end
        chk("stream_drain", 32'(q.size()), 32'd0);

        // Saturating counter, then clear coincident with an error transfer.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 7'h45, 1'b1, 1'b0);
            step(1'b0, 7'h00, 1'b1, 1'b0);
            step(1'b0, 7'h00, 1'b1, 1'b0);
            chk("cnt_sat", 32'(err_count), 32'((k < CNT_MAX) ? k : CNT_MAX));
        end
        step(1'b1, 7'h45, 1'b1, 1'b0);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        chk("clr_pending", 32'({out_valid, out_err}), 32'b11);
        step(1'b0, 7'h00, 1'b1, 1'b1);
        chk("cnt_clear", 32'(err_count), 32'd0);

        // Reset with both stages full and stalled: nothing may emerge afterwards.
        step(1'b1, 7'h45, 1'b0, 1'b0);
        step(1'b1, 7'h55, 1'b0, 1'b0);
        chk("midrst_full", 32'({out_valid, in_ready}), 32'b10);
        do_reset();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnt", 32'(err_count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 7'h00, 1'b1, 1'b0);
            chk("midrst_quiet", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
